// File: rtl/demux2_pkg.sv
// demux2_pkg: shared slot encoding, width defaults and counter limits for demux2_slot_router.
package demux2_pkg;
    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} slot_state_e;
    localparam int SIZE_DEF = 6;
    localparam int COUNT_W = 16;
    localparam logic [COUNT_W-1:0] COUNT_MAX = 16'hFFFF;
    function automatic logic [COUNT_W-1:0] sat_inc(input logic [COUNT_W-1:0] c);
        return (c == COUNT_MAX) ? c : c + 1'b1;
    endfunction
endpackage

// File: rtl/demux2_slot.sv
// demux2_slot: single-entry holding slot with EMPTY/FULL FSM and same-cycle drain+reload.
// Optional saturating drain counter when DEMUX2_COUNT_EN is defined.
module demux2_slot
    import demux2_pkg::*;
#(
    parameter int SIZE = SIZE_DEF
) (
    input  logic            Clock,
    input  logic            Reset,
    input  logic            load_i,
    input  logic [SIZE-1:0] data_i,
    input  logic            ready_i,
    output logic            accept_o,
    output logic            valid_o,
    output logic [SIZE-1:0] data_o
`ifdef DEMUX2_COUNT_EN
    ,
    output logic [COUNT_W-1:0] count_o
`endif
);
    slot_state_e     state_q, state_d;
    logic [SIZE-1:0] data_q, data_d;
    logic            drain;

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q <= EMPTY;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
        end
    end

    // a reload in the drain cycle keeps the slot FULL with no bubble
    always_comb begin
        state_d = load_i ? FULL : (drain ? EMPTY : state_q);
        data_d  = load_i ? data_i : data_q;
    end

    always_comb begin
        valid_o  = (state_q == FULL);
        drain    = valid_o && ready_i;
        accept_o = !valid_o || ready_i;
        data_o   = data_q;
    end

`ifdef DEMUX2_COUNT_EN
    logic [COUNT_W-1:0] count_q, count_d;

    always_ff @(posedge Clock) begin
        if (Reset) count_q <= '0;
        else       count_q <= count_d;
    end

    always_comb count_d = drain ? sat_inc(count_q) : count_q;

    assign count_o = count_q;
`endif
endmodule

// File: rtl/demux2_slot_router.sv
// demux2_slot_router: routes a valid/ready stream into slot A or B by wSelect.
// Per-slot drain counters are added when DEMUX2_COUNT_EN is defined.
module demux2_slot_router
    import demux2_pkg::*;
#(
    parameter int SIZE = SIZE_DEF
) (
    input  logic            Clock,
    input  logic            Reset,
    input  logic            wValid,
    input  logic            wSelect,
    input  logic [SIZE-1:0] wData,
    output logic            wReadyIn,
    output logic            rValidA,
    output logic [SIZE-1:0] rDataA,
    input  logic            wReadyA,
    output logic            rValidB,
    output logic [SIZE-1:0] rDataB,
    input  logic            wReadyB
`ifdef DEMUX2_COUNT_EN
    ,
    output logic [COUNT_W-1:0] rCountA,
    output logic [COUNT_W-1:0] rCountB
`endif
);
    logic accept_a, accept_b, load_a, load_b;

    // only the selected slot gates acceptance; held low during reset
    always_comb begin
        wReadyIn = !Reset && (wSelect ? accept_b : accept_a);
        load_a   = wValid && wReadyIn && !wSelect;
        load_b   = wValid && wReadyIn && wSelect;
    end

    demux2_slot #(.SIZE(SIZE)) u_slot_a (
        .Clock   (Clock),
        .Reset   (Reset),
        .load_i  (load_a),
        .data_i  (wData),
        .ready_i (wReadyA),
        .accept_o(accept_a),
        .valid_o (rValidA),
        .data_o  (rDataA)
`ifdef DEMUX2_COUNT_EN
        ,
        .count_o (rCountA)
`endif
    );

    demux2_slot #(.SIZE(SIZE)) u_slot_b (
        .Clock   (Clock),
        .Reset   (Reset),
        .load_i  (load_b),
        .data_i  (wData),
        .ready_i (wReadyB),
        .accept_o(accept_b),
        .valid_o (rValidB),
        .data_o  (rDataB)
`ifdef DEMUX2_COUNT_EN
        ,
        .count_o (rCountB)
`endif
    );
endmodule

// File: tb/tb_demux2_slot_router.sv
// tb_demux2_slot_router: vector table plus scoreboard bench for demux2_slot_router.
// Counter checks run only when DEMUX2_COUNT_EN is defined.
module tb_demux2_slot_router;
    logic       Clock = 1'b0;
    logic       Reset, wValid, wSelect, wReadyA, wReadyB;
    logic [5:0] wData;
    logic       wReadyIn, rValidA, rValidB;
    logic [5:0] rDataA, rDataB;
`ifdef DEMUX2_COUNT_EN
    logic [15:0] rCountA, rCountB;
`endif

    int checks = 0;
    int errors = 0;
    logic [5:0] q_a[$];
    logic [5:0] q_b[$];

    demux2_slot_router dut (
        .Clock   (Clock),
        .Reset   (Reset),
        .wValid  (wValid),
        .wSelect (wSelect),
        .wData   (wData),
        .wReadyIn(wReadyIn),
        .rValidA (rValidA),
        .rDataA  (rDataA),
        .wReadyA (wReadyA),
        .rValidB (rValidB),
        .rDataB  (rDataB),
        .wReadyB (wReadyB)
`ifdef DEMUX2_COUNT_EN
        ,
        .rCountA (rCountA),
        .rCountB (rCountB)
`endif
    );

    always #5 Clock = ~Clock;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic apply(input logic v, input logic s, input logic [5:0] d, input logic ra, input logic rb);
        wValid = v; wSelect = s; wData = d; wReadyA = ra; wReadyB = rb;
    endtask

    task automatic next_cycle();
        @(posedge Clock);
        #1;
    endtask

    // scoreboard: handshakes seen at negedge complete at the following posedge
    always @(negedge Clock) begin
        if (Reset) begin
            q_a.delete();
            q_b.delete();
        end else begin
            if (rValidA && wReadyA) begin
                if (q_a.size() == 0) chk("sb_a_unexpected", 1, 0);
                else chk("sb_a_data", rDataA, q_a.pop_front());
            end
            if (rValidB && wReadyB) begin
                if (q_b.size() == 0) chk("sb_b_unexpected", 1, 0);
                else chk("sb_b_data", rDataB, q_b.pop_front());
            end
            if (wValid && wReadyIn) begin
                if (wSelect) q_b.push_back(wData);
                else q_a.push_back(wData);
            end
        end
    end

    typedef struct {
        logic v, s;
        logic [5:0] d;
        logic ra, rb;
        logic e_rdy, e_va;
        logic [5:0] e_da;
        logic e_vb;
        logic [5:0] e_db;
    } vec_t;

    vec_t vt[10];

    initial begin
        // inputs, then expected wReadyIn and current slot contents before the edge
        vt[0] = '{1'b1, 1'b0, 6'h15, 1'b1, 1'b0, 1'b1, 1'b0, 6'h00, 1'b0, 6'h00};
        vt[1] = '{1'b1, 1'b0, 6'h2A, 1'b0, 1'b0, 1'b0, 1'b1, 6'h15, 1'b0, 6'h00};
        vt[2] = '{1'b1, 1'b0, 6'h2A, 1'b0, 1'b0, 1'b0, 1'b1, 6'h15, 1'b0, 6'h00};
        vt[3] = '{1'b1, 1'b0, 6'h2A, 1'b1, 1'b0, 1'b1, 1'b1, 6'h15, 1'b0, 6'h00};
        vt[4] = '{1'b1, 1'b1, 6'h07, 1'b0, 1'b0, 1'b1, 1'b1, 6'h2A, 1'b0, 6'h00};
        vt[5] = '{1'b0, 1'b1, 6'h3F, 1'b0, 1'b0, 1'b0, 1'b1, 6'h2A, 1'b1, 6'h07};
        vt[6] = '{1'b1, 1'b0, 6'h11, 1'b0, 1'b0, 1'b0, 1'b1, 6'h2A, 1'b1, 6'h07};
        vt[7] = '{1'b1, 1'b1, 6'h12, 1'b0, 1'b0, 1'b0, 1'b1, 6'h2A, 1'b1, 6'h07};
        vt[8] = '{1'b0, 1'b0, 6'h00, 1'b1, 1'b1, 1'b1, 1'b1, 6'h2A, 1'b1, 6'h07};
        vt[9] = '{1'b0, 1'b0, 6'h00, 1'b0, 1'b0, 1'b1, 1'b0, 6'h00, 1'b0, 6'h00};

        Reset = 1'b1;
        apply(1'b0, 1'b0, 6'h00, 1'b0, 1'b0);
        next_cycle();
        @(negedge Clock);
        chk("rst_ready_in", wReadyIn, 0);
        chk("rst_valid_a", rValidA, 0);
        chk("rst_data_a", rDataA, 0);
        chk("rst_valid_b", rValidB, 0);
        chk("rst_data_b", rDataB, 0);
        next_cycle();
        Reset = 1'b0;

        for (int i = 0; i < 10; i++) begin
            apply(vt[i].v, vt[i].s, vt[i].d, vt[i].ra, vt[i].rb);
            @(negedge Clock);
            chk($sformatf("vec%0d_ready_in", i), wReadyIn, vt[i].e_rdy);
            chk($sformatf("vec%0d_valid_a", i), rValidA, vt[i].e_va);
            chk($sformatf("vec%0d_valid_b", i), rValidB, vt[i].e_vb);
            if (vt[i].e_va) chk($sformatf("vec%0d_data_a", i), rDataA, vt[i].e_da);
            if (vt[i].e_vb) chk($sformatf("vec%0d_data_b", i), rDataB, vt[i].e_db);
            next_cycle();
        end

        // back-to-back stream into B: one word per cycle, latency 1
        for (int i = 0; i < 8; i++) begin
            apply(1'b1, 1'b1, 6'(i), 1'b0, 1'b1);
            @(negedge Clock);
            chk($sformatf("stream%0d_ready_in", i), wReadyIn, 1);
            if (i > 0) begin
                chk($sformatf("stream%0d_valid_b", i), rValidB, 1);
                chk($sformatf("stream%0d_data_b", i), rDataB, i - 1);
            end
            next_cycle();
        end
        apply(1'b0, 1'b0, 6'h00, 1'b0, 1'b1);
        @(negedge Clock);
        chk("stream_last_data_b", rDataB, 7);
        next_cycle();
        apply(1'b0, 1'b0, 6'h00, 1'b0, 1'b0);
        @(negedge Clock);
        chk("stream_drained_b", rValidB, 0);
        next_cycle();

        // reset with both slots full
        apply(1'b1, 1'b0, 6'h33, 1'b0, 1'b0);
        next_cycle();
        apply(1'b1, 1'b1, 6'h0C, 1'b0, 1'b0);
        next_cycle();
        apply(1'b1, 1'b1, 6'h01, 1'b0, 1'b0);
        Reset = 1'b1;
        @(negedge Clock);
        chk("mid_rst_full_a", rValidA, 1);
        chk("mid_rst_full_b", rValidB, 1);
        chk("mid_rst_ready_in", wReadyIn, 0);
        next_cycle();
        Reset = 1'b0;
        apply(1'b1, 1'b0, 6'h01, 1'b0, 1'b0);
        @(negedge Clock);
        chk("post_rst_valid_a", rValidA, 0);
        chk("post_rst_data_a", rDataA, 0);
        chk("post_rst_valid_b", rValidB, 0);
        chk("post_rst_data_b", rDataB, 0);
        chk("post_rst_ready_in", wReadyIn, 1);
        next_cycle();
        apply(1'b0, 1'b0, 6'h00, 1'b1, 1'b1);
        next_cycle();
        apply(1'b0, 1'b0, 6'h00, 1'b0, 1'b0);
        @(negedge Clock);
        chk("final_valid_a", rValidA, 0);

`ifdef DEMUX2_COUNT_EN
        Reset = 1'b1;
        next_cycle();
        Reset = 1'b0;
        @(negedge Clock);
        chk("cnt_rst_a", rCountA, 0);
        chk("cnt_rst_b", rCountB, 0);
        for (int i = 0; i < 3; i++) begin
            apply(1'b1, 1'b0, 6'(i), 1'b1, 1'b1);
            next_cycle();
        end
        for (int i = 0; i < 5; i++) begin
            apply(1'b1, 1'b1, 6'(i), 1'b1, 1'b1);
            next_cycle();
        end
        apply(1'b0, 1'b0, 6'h00, 1'b1, 1'b1);
        next_cycle();
        @(negedge Clock);
        chk("cnt_a_3", rCountA, 3);
        chk("cnt_b_5", rCountB, 5);
        for (int i = 0; i < 65540; i++) begin
            apply(1'b1, 1'b1, 6'(i), 1'b0, 1'b1);
            next_cycle();
        end
        apply(1'b0, 1'b0, 6'h00, 1'b0, 1'b1);
        next_cycle();
        apply(1'b0, 1'b0, 6'h00, 1'b0, 1'b0);
        @(negedge Clock);
        chk("cnt_b_sat", rCountB, 16'hFFFF);
        chk("cnt_a_hold", rCountA, 3);
`endif

        next_cycle();
        @(negedge Clock);
        chk("sb_a_empty", q_a.size(), 0);
        chk("sb_b_empty", q_b.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
